hwag_div_sched: RTL

Shared division scheduler for the hwag delta-angle path. It replaces one divider per consumer with a single iterative restoring divider, time-multiplexed among NREQ requesters. Current consumers are ignition charge time and injection time, each divided by the corrected SCNT top. Requests are latched and arbitrated round-robin. Each requester gets a registered quotient and a one-cycle done pulse.

---
 rtl/hwag_div_sched.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hwag_div_sched.sv
// Shared division scheduler: per-requester request latch, round-robin grant
// and a single iterative restoring divider producing registered quotients.
module hwag_div_sched #(
  parameter int WIDTH = 24,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]      divider,
  output logic [NREQ*WIDTH-1:0] result,
  output logic [NREQ-1:0]       done,
  output logic                  err_dz,
  output logic                  busy,
  output logic [IDW-1:0]        gnt_id
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t           state, state_next;
  logic [NREQ-1:0]  pending, grant_mask;
  logic [IDW-1:0]   ptr, grant_id, idx;
  logic             found, do_grant, div_zero, qbit;
  logic [WIDTH-1:0] dvd, dsr, quo, rem, rem_next, quo_next;
  logic [WIDTH:0]   rem_shift, diff;
  logic [CW-1:0]    cnt;

  assign do_grant = (state == IDLE) && ena && (|pending);
  assign div_zero = (divider == '0);
  assign busy     = (state != IDLE);

  // Round-robin scan starting just after the last granted requester.
  always_comb begin
    grant_id   = ptr;
    grant_mask = '0;
    found      = 1'b0;
    idx        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && pending[idx]) begin
        found    = 1'b1;
        grant_id = idx;
      end
    end
    if (do_grant) grant_mask[grant_id] = 1'b1;
  end

  // One restoring step; the extra remainder bit keeps the quotient exact for any divisor.
  always_comb begin
    rem_shift = {rem, dvd[WIDTH-1]};
    diff      = rem_shift - {1'b0, dsr};
    qbit      = ~diff[WIDTH];
    rem_next  = qbit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], qbit};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (do_grant) state_next = div_zero ? DONE : DIV;
      DIV:  if (cnt == '0) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      ptr     <= IDW'(NREQ - 1);
      gnt_id  <= '0;
      result  <= '0;
      done    <= '0;
      err_dz  <= 1'b0;
      dvd     <= '0;
      dsr     <= '0;
      quo     <= '0;
      rem     <= '0;
      cnt     <= '0;
    end else begin
      done   <= '0;
      err_dz <= 1'b0;
      // A request on the grant edge re-arms the requester for another division.
      if (!ena) pending <= '0;
      else      pending <= (pending & ~grant_mask) | req;
      case (state)
        IDLE: begin
          if (do_grant) begin
            ptr    <= grant_id;
            gnt_id <= grant_id;
            if (div_zero) begin
              result[int'(grant_id)*WIDTH +: WIDTH] <= '1;
              done[grant_id] <= 1'b1;
              err_dz         <= 1'b1;
            end else begin
              dvd <= dividend[int'(grant_id)*WIDTH +: WIDTH];
              dsr <= divider;
              quo <= '0;
              rem <= '0;
              cnt <= CW'(WIDTH - 1);
            end
          end
        end
        DIV: begin
          dvd <= {dvd[WIDTH-2:0], 1'b0};
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            result[int'(gnt_id)*WIDTH +: WIDTH] <= quo_next;
            done[gnt_id] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
